// File: rtl/shrimp_execute_if.sv
`default_nettype none
// ============================================================================
// Module   : shrimp_execute_if
// Purpose  : Operation handshake and register-file write bundle of the execute stage.
// Revision : 1.0
// ============================================================================
interface shrimp_execute_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [ADDR_W-1:0] in_dst;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic              wb_enable;
    logic [ADDR_W-1:0] wb_addr;
    logic [WIDTH-1:0]  wb_val;
    logic              flag_z;
    logic              flag_c;
    logic              busy;

    modport master (
        output in_valid, in_op, in_dst, in_a, in_b,
        input  in_ready, wb_enable, wb_addr, wb_val, flag_z, flag_c, busy
    );

    modport slave (
        input  in_valid, in_op, in_dst, in_a, in_b,
        output in_ready, wb_enable, wb_addr, wb_val, flag_z, flag_c, busy
    );
endinterface

`default_nettype wire

// File: rtl/shrimp_execute.sv
`default_nettype none
// ============================================================================
// Module   : shrimp_execute
// Purpose  : ALU execute stage feeding the register-file write port; the
//            multi-cycle shift-add MUL exists only when SHRIMP_MUL_EN is defined.
// Revision : 1.0
// ============================================================================
module shrimp_execute #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    shrimp_execute_if.slave    bus
);
    localparam logic [3:0] C_OP_ADD = 4'd0;
    localparam logic [3:0] C_OP_SUB = 4'd1;
    localparam logic [3:0] C_OP_AND = 4'd2;
    localparam logic [3:0] C_OP_OR  = 4'd3;
    localparam logic [3:0] C_OP_XOR = 4'd4;
    localparam logic [3:0] C_OP_SHL = 4'd5;
    localparam logic [3:0] C_OP_SHR = 4'd6;
    localparam logic [3:0] C_OP_MOV = 4'd7;

    logic [WIDTH:0]    w_sum;
    logic [WIDTH:0]    w_diff;
    logic [WIDTH-1:0]  w_result;
    logic              w_carry;
    logic              w_writes;
    logic              w_ready;
    logic              w_busy;
    logic              w_accept;

    logic              r_wb_enable;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [WIDTH-1:0]  r_wb_val;
    logic              r_flag_z;
    logic              r_flag_c;

    assign w_sum    = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    assign w_diff   = {1'b0, bus.in_a} - {1'b0, bus.in_b};
    assign w_accept = bus.in_valid && w_ready;

    // Single-cycle ALU; MUL and NOP opcodes fall to default (no immediate writeback).
    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        w_writes = 1'b1;
        case (bus.in_op)
            C_OP_ADD: begin w_result = w_sum[WIDTH-1:0];  w_carry = w_sum[WIDTH];  end
            C_OP_SUB: begin w_result = w_diff[WIDTH-1:0]; w_carry = w_diff[WIDTH]; end
            C_OP_AND: w_result = bus.in_a & bus.in_b;
            C_OP_OR:  w_result = bus.in_a | bus.in_b;
            C_OP_XOR: w_result = bus.in_a ^ bus.in_b;
            C_OP_SHL: begin w_result = {bus.in_a[WIDTH-2:0], 1'b0}; w_carry = bus.in_a[WIDTH-1]; end
            C_OP_SHR: begin w_result = {1'b0, bus.in_a[WIDTH-1:1]}; w_carry = bus.in_a[0];       end
            C_OP_MOV: w_result = bus.in_b;
            default:  w_writes = 1'b0;
        endcase
    end

`ifdef SHRIMP_MUL_EN
    localparam logic [3:0] C_OP_MUL = 4'd8;
    localparam int         CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_a_shift;
    logic [WIDTH-1:0]  r_b_shift;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_mul_dst;
    logic [WIDTH-1:0]  w_acc_next;
    logic              w_mul_start;
    logic              w_mul_last;

    assign w_ready     = (r_state == S_IDLE);
    assign w_busy      = (r_state == S_MUL);
    assign w_mul_start = w_accept && (bus.in_op == C_OP_MUL);
    assign w_mul_last  = w_busy && (r_count == CNT_W'(WIDTH - 1));
    assign w_acc_next  = r_acc + (r_b_shift[0] ? r_a_shift : '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_mul_start) w_state_next = S_MUL;
            S_MUL:   if (w_mul_last)  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc     <= '0;
            r_a_shift <= '0;
            r_b_shift <= '0;
            r_count   <= '0;
            r_mul_dst <= '0;
        end else if (w_mul_start) begin
            r_acc     <= '0;
            r_a_shift <= bus.in_a;
            r_b_shift <= bus.in_b;
            r_count   <= '0;
            r_mul_dst <= bus.in_dst;
        end else if (w_busy) begin
            r_acc     <= w_acc_next;
            r_a_shift <= {r_a_shift[WIDTH-2:0], 1'b0};
            r_b_shift <= {1'b0, r_b_shift[WIDTH-1:1]};
            r_count   <= r_count + 1'b1;
        end
    end
`else
    assign w_ready = 1'b1;
    assign w_busy  = 1'b0;
`endif

    // Writeback register: one-cycle strobe; address/value/flags hold between results.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wb_enable <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_val    <= '0;
            r_flag_z    <= 1'b0;
            r_flag_c    <= 1'b0;
        end else begin
            r_wb_enable <= 1'b0;
            if (w_accept && w_writes) begin
                r_wb_enable <= 1'b1;
                r_wb_addr   <= bus.in_dst;
                r_wb_val    <= w_result;
                r_flag_z    <= (w_result == '0);
                r_flag_c    <= w_carry;
            end
`ifdef SHRIMP_MUL_EN
            else if (w_mul_last) begin
                r_wb_enable <= 1'b1;
                r_wb_addr   <= r_mul_dst;
                r_wb_val    <= w_acc_next;
                r_flag_z    <= (w_acc_next == '0);
                r_flag_c    <= 1'b0;
            end
`endif
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.busy      = w_busy;
    assign bus.wb_enable = r_wb_enable;
    assign bus.wb_addr   = r_wb_addr;
    assign bus.wb_val    = r_wb_val;
    assign bus.flag_z    = r_flag_z;
    assign bus.flag_c    = r_flag_c;
endmodule

`default_nettype wire

// File: tb/tb_shrimp_execute.sv
`default_nettype none
// ============================================================================
// Module   : tb_shrimp_execute
// Purpose  : Scoreboard bench for shrimp_execute against an arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_shrimp_execute;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = 4;
`ifdef SHRIMP_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] addr;
        logic [7:0] val;
        logic       z;
        logic       c;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    shrimp_execute_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    shrimp_execute #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t       sb[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    int         mul_acc     = -1000;
    logic [7:0] m_val       = '0;
    logic [3:0] m_addr      = '0;
    logic       m_z         = 1'b0;
    logic       m_c         = 1'b0;

    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: results straight from integer arithmetic modulo 256.
    function automatic bit ref_op(input int op, input int a, input int b,
                                  output logic [7:0] r, output logic c);
        int x;
        c = 1'b0;
        x = 0;
        case (op)
            0: begin x = a + b; c = (x > 255); end
            1: begin x = a - b; c = (a < b);   end
            2: x = a & b;
            3: x = a | b;
            4: x = a ^ b;
            5: begin x = a * 2; c = (a >= 128); end
            6: begin x = a / 2; c = (a % 2 == 1); end
            7: x = b;
            8: begin
                if (!MUL_EN) begin r = '0; return 1'b0; end
                x = a * b;
            end
            default: begin r = '0; return 1'b0; end
        endcase
        r = 8'(((x % 256) + 256) % 256);
        return 1'b1;
    endfunction

    // Monitor: pops expected results on each strobe; otherwise checks hold behaviour.
    always @(negedge clock) begin
        bit   exp_busy;
        exp_t e;
        if (reset) begin
            sb.delete();
            m_val = '0; m_addr = '0; m_z = 1'b0; m_c = 1'b0;
            check("rst_wb_enable", bus.wb_enable, 0);
            check("rst_wb_addr",   bus.wb_addr,   0);
            check("rst_wb_val",    bus.wb_val,    0);
            check("rst_flag_z",    bus.flag_z,    0);
            check("rst_flag_c",    bus.flag_c,    0);
            check("rst_busy",      bus.busy,      0);
            check("rst_in_ready",  bus.in_ready,  1);
        end else begin
            exp_busy = MUL_EN && (cyc > mul_acc) && (cyc <= mul_acc + WIDTH);
            check("busy",     bus.busy,     exp_busy);
            check("in_ready", bus.in_ready, !exp_busy);
            if (bus.wb_enable) begin
                if (sb.size() == 0) begin
                    check("unexpected_wb", bus.wb_enable, 0);
                end else begin
                    e = sb.pop_front();
                    check("wb_cycle", cyc,         e.cyc);
                    check("wb_addr",  bus.wb_addr, e.addr);
                    check("wb_val",   bus.wb_val,  e.val);
                    check("flag_z",   bus.flag_z,  e.z);
                    check("flag_c",   bus.flag_c,  e.c);
                    m_val = e.val; m_addr = e.addr; m_z = e.z; m_c = e.c;
                end
            end else begin
                check("hold_addr",   bus.wb_addr, m_addr);
                check("hold_val",    bus.wb_val,  m_val);
                check("hold_flag_z", bus.flag_z,  m_z);
                check("hold_flag_c", bus.flag_c,  m_c);
                if (sb.size() > 0 && cyc > sb[0].cyc) begin
                    check("missing_wb", bus.wb_enable, 1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [3:0] dst,
                         input logic [7:0] a, input logic [7:0] b);
        int         w;
        int         acc;
        logic [7:0] r;
        logic       c;
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_dst   = dst;
        bus.in_a     = a;
        bus.in_b     = b;
        w = 0;
        while (!bus.in_ready && w < 64) begin
            @(negedge clock);
            w++;
        end
        if (bus.in_ready) begin
            acc = cyc;
            if (ref_op(int'(op), int'(a), int'(b), r, c))
                sb.push_back('{cyc: acc + ((op == 4'd8) ? WIDTH + 1 : 1),
                               addr: dst, val: r, z: (r == 8'h00), c: c});
            if (MUL_EN && op == 4'd8) mul_acc = acc;
            @(posedge clock);
        end
        #1 bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        bus.in_dst   = '0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;

        issue(4'd0, 4'd3, 8'hF0, 8'h20);
        issue(4'd1, 4'd1, 8'h05, 8'h05);
        issue(4'd1, 4'd2, 8'h01, 8'h02);
        issue(4'd6, 4'd7, 8'h01, 8'h00);
        issue(4'd12, 4'd4, 8'h33, 8'h44);
        issue(4'd5, 4'd5, 8'h81, 8'h00);
        issue(4'd7, 4'd6, 8'h00, 8'h5A);
        repeat (3) @(negedge clock);

        issue(4'd8, 4'd2, 8'h0D, 8'h0B);
        issue(4'd0, 4'd9, 8'h01, 8'h01);
        issue(4'd8, 4'd1, 8'h10, 8'h10);
        repeat (12) @(negedge clock);

        issue(4'd8, 4'd3, 8'hFF, 8'hFF);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        mul_acc = -1000;
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        repeat (12) @(negedge clock);

        for (int i = 0; i < 400; i++) begin
            issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
        end

        repeat (20) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

`default_nettype wire
